// File: rtl/otbn_pkg.sv
// rtl/otbn_pkg.sv - OTBN IMEM responder types, inverted SECDED 39/32 encode/decode and wipe word.
package otbn_pkg;

   // IDLE and WIPE differ in all three bits, so a single upset cannot turn one into the other.
   typedef enum logic [2:0] {
      IDLE = 3'b010,
      WIPE = 3'b101
   } imem_resp_state_e;

   localparam logic [38:0] SecdedInvMask = 39'h2A_0000_0000;

   function automatic logic [38:0] prim_secded_inv_39_32_enc(input logic [31:0] data);
      logic [38:0] cw;
      cw     = {7'h00, data};
      cw[32] = ^(cw & 39'h00_2606BD25);
      cw[33] = ^(cw & 39'h00_DEBA8050);
      cw[34] = ^(cw & 39'h00_413D89AA);
      cw[35] = ^(cw & 39'h00_31234ED1);
      cw[36] = ^(cw & 39'h00_C2C1323B);
      cw[37] = ^(cw & 39'h00_2DCC624C);
      cw[38] = ^(cw & 39'h00_98505586);
      return cw ^ SecdedInvMask;
   endfunction

   // Returns {double_err, single_err}; data is reported raw, never corrected here.
   function automatic logic [1:0] prim_secded_inv_39_32_dec(input logic [38:0] cw_in);
      logic [38:0] cw;
      logic [6:0]  syn;
      cw     = cw_in ^ SecdedInvMask;
      syn[0] = ^(cw & 39'h01_2606BD25);
      syn[1] = ^(cw & 39'h02_DEBA8050);
      syn[2] = ^(cw & 39'h04_413D89AA);
      syn[3] = ^(cw & 39'h08_31234ED1);
      syn[4] = ^(cw & 39'h10_C2C1323B);
      syn[5] = ^(cw & 39'h20_2DCC624C);
      syn[6] = ^(cw & 39'h40_98505586);
      return {(|syn) & ~(^syn), ^syn};
   endfunction

   localparam logic [38:0] ImemWipeWord = prim_secded_inv_39_32_enc(32'h0);

endpackage

// File: rtl/otbn_imem_ram.sv
// rtl/otbn_imem_ram.sv - single-port Words x Width array with registered read data.
module otbn_imem_ram #(
   parameter int Words = 1024,
   parameter int Width = 39,
   localparam int AddrWidth = $clog2(Words)
) (
   input  logic                 clk,
   input  logic                 req,
   input  logic                 we,
   input  logic [AddrWidth-1:0] addr,
   input  logic [Width-1:0]     wdata,
   output logic [Width-1:0]     rdata
);

   logic [Width-1:0] mem [Words];

   // rdata only moves on a read, so it holds across idle and write cycles.
   always_ff @(posedge clk) begin
      if (req) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/otbn_imem_resp.sv
// rtl/otbn_imem_resp.sv - OTBN IMEM responder: core/host port mux, secure wipe, response pipeline.
// Optional host read integrity check: OTBN_IMEM_HOST_INTG_CHECK_EN.
module otbn_imem_resp
   import otbn_pkg::*;
#(
   parameter int ImemSizeByte = 4096,
   localparam int ImemAddrWidth = $clog2(ImemSizeByte)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     imem_req_i,
   input  logic [ImemAddrWidth-1:0] imem_addr_i,
   output logic [38:0]              imem_rdata_o,
   output logic                     imem_rvalid_o,
   input  logic                     busy_i,
   input  logic                     host_req_i,
   input  logic                     host_we_i,
   input  logic [ImemAddrWidth-1:0] host_addr_i,
   input  logic [31:0]              host_wdata_i,
   output logic                     host_gnt_o,
   output logic                     host_rvalid_o,
   output logic [31:0]              host_rdata_o,
   output logic                     host_err_o,
   input  logic                     wipe_req_i,
   output logic                     wipe_busy_o,
   output logic                     wipe_done_o
);

   localparam int Words    = ImemSizeByte / 4;
   localparam int IdxWidth = ImemAddrWidth - 2;
   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(Words - 1);

   imem_resp_state_e    state_q, state_d;
   logic [IdxWidth-1:0] counter_q, counter_d;

   logic                idle, in_wipe;
   logic                core_read, host_write, host_read;
   logic                ram_req, ram_we;
   logic [IdxWidth-1:0] ram_addr;
   logic [38:0]         ram_wdata, ram_rdata;

   logic                imem_rvalid_q;
   logic [38:0]         imem_hold_q;
   logic                host_rvalid_q, host_lock_q, host_read_q;
   logic                intg_err;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^{imem_addr_i[1:0], host_addr_i[1:0]};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         counter_q <= '0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
      end
   end

   // Terminal count is caught before the counter wraps, so word 0 is never rewritten.
   always_comb begin
      state_d     = state_q;
      counter_d   = counter_q;
      wipe_done_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (wipe_req_i) begin
               state_d   = WIPE;
               counter_d = '0;
            end
         end
         WIPE: begin
            counter_d = counter_q + 1'b1;
            if (counter_q == LastIdx) begin
               state_d     = IDLE;
               wipe_done_o = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign idle        = (state_q == IDLE);
   assign in_wipe     = (state_q == WIPE);
   assign wipe_busy_o = in_wipe;

   // While busy the host is granted but locked out; it only touches the array when the core is idle.
   assign host_gnt_o = idle & host_req_i;
   assign core_read  = idle & busy_i & imem_req_i;
   assign host_write = host_gnt_o & ~busy_i & host_we_i;
   assign host_read  = host_gnt_o & ~busy_i & ~host_we_i;

   assign ram_req   = in_wipe | core_read | host_write | host_read;
   assign ram_we    = in_wipe | host_write;
   assign ram_addr  = in_wipe ? counter_q :
                      busy_i  ? imem_addr_i[ImemAddrWidth-1:2] : host_addr_i[ImemAddrWidth-1:2];
   assign ram_wdata = in_wipe ? ImemWipeWord : prim_secded_inv_39_32_enc(host_wdata_i);

   otbn_imem_ram #(
      .Words (Words),
      .Width (39)
   ) u_ram (
      .clk   (clk_i),
      .req   (ram_req),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         imem_rvalid_q <= 1'b0;
         imem_hold_q   <= '0;
         host_rvalid_q <= 1'b0;
         host_lock_q   <= 1'b0;
         host_read_q   <= 1'b0;
      end else begin
         imem_rvalid_q <= core_read;
         if (imem_rvalid_q) begin
            imem_hold_q <= ram_rdata;
         end
         host_rvalid_q <= host_gnt_o;
         host_lock_q   <= host_gnt_o & busy_i;
         host_read_q   <= host_read;
      end
   end

   // The RAM output is shared with host reads, so the core sees a private held copy between responses.
   assign imem_rvalid_o = imem_rvalid_q;
   assign imem_rdata_o  = imem_rvalid_q ? ram_rdata : imem_hold_q;
   assign host_rvalid_o = host_rvalid_q;
   assign host_rdata_o  = host_read_q ? ram_rdata[31:0] : 32'h0;

`ifdef OTBN_IMEM_HOST_INTG_CHECK_EN
   assign intg_err = host_read_q & (|prim_secded_inv_39_32_dec(ram_rdata));
`else
   assign intg_err = 1'b0;
`endif

   assign host_err_o = host_lock_q | intg_err;

endmodule
